tx_multi_pulser: RTL and testbench

//  Parametrised successor of the transmitter single pulser: N independent button/strobe

---
 rtl/tx_multi_pulser.sv | 144 ++++++++++++++
 tb/tb_tx_multi_pulser.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_multi_pulser.sv
// N-channel button pulser: per-channel synchroniser, debouncer and press/repeat FSM.
// held and pulser_out are both registered; channels share no state.
module tx_multi_pulser #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] pulser_in,
  input  logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] pulser_out,
  output logic [CHANNELS-1:0] held
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  // Raw level that means "released"; also the reset value of the sync chain.
  localparam logic REL_LVL = (ACTIVE_LOW != 0);
  localparam bit   RPT_EN  = (REPEAT_DELAY > 0);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DW-1:0]          db_cnt;
    logic                   held_q;
    logic                   toggle;
    logic                   rise;
    logic                   fall;
    state_t                 state_q;
    state_t                 state_d;
    logic [RW-1:0]          rcnt_q;
    logic [RW-1:0]          rcnt_d;
    logic                   pulse_d;
    logic                   pulse_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= {SYNC_STAGES{REL_LVL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pulser_in[i]};
      end
    end

    // s = 1 means pressed regardless of input polarity.
    assign s = sync_q[SYNC_STAGES-1] ^ REL_LVL;

    // Level change is accepted on the edge that would make the mismatch run DEBOUNCE_CYCLES long.
    assign toggle = (s != held_q) && (db_cnt == DB_LAST);
    assign rise   = toggle && !held_q;
    assign fall   = toggle && held_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        db_cnt <= '0;
        held_q <= 1'b0;
      end else if (s == held_q) begin
        db_cnt <= '0;
      end else if (toggle) begin
        db_cnt <= '0;
        held_q <= ~held_q;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= ST_IDLE;
        rcnt_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
        pulse_q <= pulse_d;
      end
    end

    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      pulse_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          rcnt_d = '0;
          if (rise) begin
            state_d = ST_ARM;
            pulse_d = enable[i];
          end
        end
        ST_ARM: begin
          if (fall) begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end else if (!enable[i] || !RPT_EN) begin
            rcnt_d = '0;
          end else if (rcnt_q == RD_LAST) begin
            state_d = ST_REPEAT;
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (fall) begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end else if (!enable[i]) begin
            rcnt_d = '0;
          end else if (rcnt_q == RP_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    assign pulser_out[i] = pulse_q;
    assign held[i]       = held_q;
  end

endmodule

// File: tb/tb_tx_multi_pulser.sv
// Bench for tx_multi_pulser: a default instance and a repeat-enabled instance share inputs
// and are compared every cycle against a schedule-based reference model.
`timescale 1ns/1ps
module tb_tx_multi_pulser;

  localparam int CH   = 4;
  localparam int SS   = 2;
  localparam int DB   = 16;
  localparam int RD_B = 20;
  localparam int RP_B = 8;
  localparam int LAT  = SS + DB - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] pulser_in;
  logic [CH-1:0] enable;
  logic [CH-1:0] pa, ha, pb, hb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tx_multi_pulser #(.CHANNELS(CH)) dut_a (
    .clk(clk), .reset(reset), .pulser_in(pulser_in), .enable(enable),
    .pulser_out(pa), .held(ha)
  );

  tx_multi_pulser #(.CHANNELS(CH), .REPEAT_DELAY(RD_B), .REPEAT_PERIOD(RP_B)) dut_b (
    .clk(clk), .reset(reset), .pulser_in(pulser_in), .enable(enable),
    .pulser_out(pb), .held(hb)
  );

  // Reference model: delay line for the synchroniser, mismatch run length for the debouncer,
  // and an absolute "next repeat due" edge per channel and instance.
  logic [CH-1:0] hist[$];
  int            mis[CH];
  logic [CH-1:0] m_held;
  logic [CH-1:0] m_pulse[2];
  bit            active[2][CH];
  bit            repeating[2][CH];
  int            due[2][CH];
  int            rd_cfg[2] = '{0, RD_B};
  int            rp_cfg[2] = '{8, RP_B};
  int            edge_no = 0;

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < SS; j++) hist.push_back('0);
    m_held = '0;
    for (int n = 0; n < 2; n++) begin
      m_pulse[n] = '0;
      for (int c = 0; c < CH; c++) begin
        active[n][c]    = 1'b0;
        repeating[n][c] = 1'b0;
        due[n][c]       = 0;
      end
    end
    for (int c = 0; c < CH; c++) mis[c] = 0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] s;
    bit rise, fall;
    s = hist.pop_front();
    hist.push_back(~pulser_in);
    edge_no++;
    m_pulse[0] = '0;
    m_pulse[1] = '0;
    for (int c = 0; c < CH; c++) begin
      rise = 1'b0;
      fall = 1'b0;
      mis[c] = (s[c] != m_held[c]) ? mis[c] + 1 : 0;
      if (mis[c] == DB) begin
        mis[c]    = 0;
        m_held[c] = ~m_held[c];
        rise      = m_held[c];
        fall      = !m_held[c];
      end
      for (int n = 0; n < 2; n++) begin
        if (rise) begin
          active[n][c]    = 1'b1;
          repeating[n][c] = 1'b0;
          due[n][c]       = edge_no + rd_cfg[n];
          m_pulse[n][c]   = enable[c];
        end else if (fall) begin
          active[n][c] = 1'b0;
        end else if (active[n][c] && rd_cfg[n] > 0) begin
          if (!enable[c]) begin
            due[n][c] = edge_no + (repeating[n][c] ? rp_cfg[n] : rd_cfg[n]);
          end else if (edge_no == due[n][c]) begin
            m_pulse[n][c]   = 1'b1;
            repeating[n][c] = 1'b1;
            due[n][c]       = edge_no + rp_cfg[n];
          end
        end
      end
    end
  endtask

  // Advance one clock: model follows the rising edge, outputs are observed at the falling edge.
  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    pulser_in = '1;
    enable    = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pa, ha, pb, hb} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", {pa, ha, pb, hb});
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (3) begin
      clk_edge();
      checks++;
      if ({pa, ha, pb, hb} !== {m_pulse[0], m_held, m_pulse[1], m_held}) begin
        errors++;
        $display("FAIL reset_idle edge=%0d got=%h exp=%h", edge_no, {pa, ha, pb, hb},
                 {m_pulse[0], m_held, m_pulse[1], m_held});
      end
    end
  endtask

  task automatic test_clean_press();
    int k, pulses, first_pulse, rel, held_fall;
    pulser_in[0] = 1'b0;
    k = edge_no + 1;
    pulses = 0;
    first_pulse = -1;
    for (int i = 0; i < LAT + 40; i++) begin
      clk_edge();
      checks++;
      if ({pa, ha, pb, hb} !== {m_pulse[0], m_held, m_pulse[1], m_held}) begin
        errors++;
        $display("FAIL press_cycle edge=%0d got=%h exp=%h", edge_no, {pa, ha, pb, hb},
                 {m_pulse[0], m_held, m_pulse[1], m_held});
      end
      if (pa[0]) begin
        pulses++;
        if (first_pulse < 0) first_pulse = edge_no;
      end
    end
    checks++;
    if (pulses != 1 || first_pulse != k + 17) begin
      errors++;
      $display("FAIL press_latency pulses=%0d at_edge=%0d exp 1 at %0d", pulses, first_pulse, k + 17);
    end
    pulser_in[0] = 1'b1;
    rel = edge_no + 1;
    pulses = 0;
    held_fall = -1;
    for (int i = 0; i < LAT + 8; i++) begin
      clk_edge();
      checks++;
      if ({pa, ha, pb, hb} !== {m_pulse[0], m_held, m_pulse[1], m_held}) begin
        errors++;
        $display("FAIL release_cycle edge=%0d got=%h exp=%h", edge_no, {pa, ha, pb, hb},
                 {m_pulse[0], m_held, m_pulse[1], m_held});
      end
      if (ha[0] === 1'b0 && held_fall < 0) held_fall = edge_no;
      if (pa[0]) pulses++;
    end
    checks++;
    if (pulses != 0 || held_fall != rel + 17) begin
      errors++;
      $display("FAIL release_latency pulses=%0d fall_edge=%0d exp 0 at %0d", pulses, held_fall, rel + 17);
    end
  endtask

  task automatic test_bounce();
    int k, pulses, first_pulse, glitch;
    glitch = 0;
    for (int i = 0; i < 60; i++) begin
      pulser_in[1] = ((i / 5) % 2 == 0) ? 1'b0 : 1'b1;
      clk_edge();
      checks++;
      if ({pa, ha, pb, hb} !== {m_pulse[0], m_held, m_pulse[1], m_held}) begin
        errors++;
        $display("FAIL bounce_cycle edge=%0d got=%h exp=%h", edge_no, {pa, ha, pb, hb},
                 {m_pulse[0], m_held, m_pulse[1], m_held});
      end
      if (pa[1] || pb[1] || ha[1]) glitch++;
    end
    pulser_in[1] = 1'b0;
    k = edge_no + 1;
    pulses = 0;
    first_pulse = -1;
    for (int i = 0; i < 30; i++) begin
      clk_edge();
      checks++;
      if ({pa, ha, pb, hb} !== {m_pulse[0], m_held, m_pulse[1], m_held}) begin
        errors++;
        $display("FAIL settle_cycle edge=%0d got=%h exp=%h", edge_no, {pa, ha, pb, hb},
                 {m_pulse[0], m_held, m_pulse[1], m_held});
      end
      if (edge_no < k + 17 && (pa[1] || ha[1])) glitch++;
      if (pa[1]) begin
        pulses++;
        if (first_pulse < 0) first_pulse = edge_no;
      end
    end
    checks++;
    if (glitch != 0 || pulses != 1 || first_pulse != k + 17) begin
      errors++;
      $display("FAIL bounce_result glitch=%0d pulses=%0d at_edge=%0d exp 0,1 at %0d",
               glitch, pulses, first_pulse, k + 17);
    end
    pulser_in[1] = 1'b1;
    repeat (LAT + 4) clk_edge();
  endtask

  task automatic test_repeat();
    int k, p;
    int got_off[$];
    int exp_off[8] = '{0, 20, 28, 36, 44, 52, 60, 68};
    pulser_in[2] = 1'b0;
    k = edge_no + 1;
    p = k + 17;
    for (int i = 0; i < 100; i++) begin
      clk_edge();
      checks++;
      if ({pa, ha, pb, hb} !== {m_pulse[0], m_held, m_pulse[1], m_held}) begin
        errors++;
        $display("FAIL repeat_cycle edge=%0d got=%h exp=%h", edge_no, {pa, ha, pb, hb},
                 {m_pulse[0], m_held, m_pulse[1], m_held});
      end
      if (pb[2]) got_off.push_back(edge_no - p);
      if (edge_no == p + 52) pulser_in[2] = 1'b1;
    end
    checks++;
    if (got_off.size() != 8) begin
      errors++;
      $display("FAIL repeat_count got=%0d exp=8", got_off.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (got_off[j] != exp_off[j]) begin
          errors++;
          $display("FAIL repeat_offset idx=%0d got=%0d exp=%0d", j, got_off[j], exp_off[j]);
        end
      end
    end
  endtask

  task automatic test_enable_mask();
    int k, pulses, held_cycles;
    enable[2] = 1'b0;
    pulser_in[2] = 1'b0;
    k = edge_no + 1;
    pulses = 0;
    held_cycles = 0;
    for (int i = 0; i < LAT + 40; i++) begin
      clk_edge();
      checks++;
      if ({pa, ha, pb, hb} !== {m_pulse[0], m_held, m_pulse[1], m_held}) begin
        errors++;
        $display("FAIL enable_cycle edge=%0d got=%h exp=%h", edge_no, {pa, ha, pb, hb},
                 {m_pulse[0], m_held, m_pulse[1], m_held});
      end
      if (pa[2]) pulses++;
      if (ha[2]) held_cycles++;
      if (edge_no == k + 17 + 10) enable[2] = 1'b1;
    end
    checks++;
    if (pulses != 0 || held_cycles != 40) begin
      errors++;
      $display("FAIL enable_mask pulses=%0d held_cycles=%0d exp 0 and 40", pulses, held_cycles);
    end
    pulser_in[2] = 1'b1;
    repeat (LAT + 4) clk_edge();
  endtask

  task automatic test_all_channels_reset();
    int settle[CH], tl[CH], cd[CH], cnt[CH], first[CH];
    int k;
    pulser_in = '0;
    for (int c = 0; c < CH; c++) begin
      settle[c] = edge_no + 1;
      tl[c]     = 2 * c;
      cd[c]     = $urandom_range(1, 10);
      cnt[c]    = 0;
      first[c]  = -1;
    end
    for (int i = 0; i < 80; i++) begin
      clk_edge();
      checks++;
      if ({pa, ha, pb, hb} !== {m_pulse[0], m_held, m_pulse[1], m_held}) begin
        errors++;
        $display("FAIL multi_cycle edge=%0d got=%h exp=%h", edge_no, {pa, ha, pb, hb},
                 {m_pulse[0], m_held, m_pulse[1], m_held});
      end
      for (int c = 0; c < CH; c++) begin
        if (pa[c]) begin
          cnt[c]++;
          if (first[c] < 0) first[c] = edge_no;
        end
        if (tl[c] > 0) begin
          cd[c]--;
          if (cd[c] == 0) begin
            pulser_in[c] = ~pulser_in[c];
            tl[c]--;
            cd[c] = $urandom_range(1, 10);
            if (!pulser_in[c]) settle[c] = edge_no + 1;
          end
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (cnt[c] != 1 || first[c] != settle[c] + 17) begin
        errors++;
        $display("FAIL multi_press ch=%0d pulses=%0d at_edge=%0d exp 1 at %0d",
                 c, cnt[c], first[c], settle[c] + 17);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({pa, ha, pb, hb} !== '0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=0", {pa, ha, pb, hb});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    k = edge_no + 1;
    for (int c = 0; c < CH; c++) begin
      cnt[c]   = 0;
      first[c] = -1;
    end
    for (int i = 0; i < 30; i++) begin
      clk_edge();
      checks++;
      if ({pa, ha, pb, hb} !== {m_pulse[0], m_held, m_pulse[1], m_held}) begin
        errors++;
        $display("FAIL after_reset_cycle edge=%0d got=%h exp=%h", edge_no, {pa, ha, pb, hb},
                 {m_pulse[0], m_held, m_pulse[1], m_held});
      end
      for (int c = 0; c < CH; c++) begin
        if (pa[c]) begin
          cnt[c]++;
          if (first[c] < 0) first[c] = edge_no;
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (cnt[c] != 1 || first[c] != k + 17) begin
        errors++;
        $display("FAIL repress_after_reset ch=%0d pulses=%0d at_edge=%0d exp 1 at %0d",
                 c, cnt[c], first[c], k + 17);
      end
    end
    pulser_in = '1;
    repeat (LAT + 4) clk_edge();
  endtask

  task automatic test_random();
    int cd[CH];
    for (int c = 0; c < CH; c++) cd[c] = $urandom_range(1, 60);
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < CH; c++) begin
        cd[c]--;
        if (cd[c] == 0) begin
          pulser_in[c] = ~pulser_in[c];
          cd[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 90);
        end
        if ($urandom_range(0, 63) == 0) enable[c] = ~enable[c];
      end
      clk_edge();
      checks++;
      if ({pa, ha, pb, hb} !== {m_pulse[0], m_held, m_pulse[1], m_held}) begin
        errors++;
        $display("FAIL random_cycle edge=%0d got=%h exp=%h", edge_no, {pa, ha, pb, hb},
                 {m_pulse[0], m_held, m_pulse[1], m_held});
      end
    end
    pulser_in = '1;
    enable    = '1;
    repeat (LAT + 4) clk_edge();
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout edge=%0d", edge_no);
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_enable_mask();
    test_all_channels_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
